// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Groups the fetch stage's two buses: the synchronous instruction-memory port
// and the IF/ID pipeline register handed to decode.
//
//   imem_addr   fetch -> mem     instruction memory word address (bytes)
//   imem_rdata  mem   -> fetch   data for the address issued last cycle
//   ifid_instr  fetch -> decode  IF/ID instruction (32'h0 when a bubble)
//   ifid_pc4    fetch -> decode  IF/ID PC+4, also the JAL link value
//   ifid_valid  fetch -> decode  IF/ID holds a real instruction
//
// master: the fetch stage.  slave: memory/decode side (or a testbench).
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic [31:0]         ifid_instr;
    logic [PC_WIDTH-1:0] ifid_pc4;
    logic                ifid_valid;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. Holds the PC, drives
// a synchronous instruction memory (one cycle read latency) and registers the
// fetched word with its PC+4 for decode. Control flow (Branch/Jmp/JR from the
// controller, branch comparator result from ID) is resolved while the
// branch/jump sits in IF/ID; the two wrong-path words already in flight are
// turned into bubbles, so a taken redirect costs exactly two bubbles.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stall_i      hazard stall: freezes PC, memory address, IF/ID and state
//   branch_i     BEQ/BNE decoded from the IF/ID instruction
//   br_taken_i   ID comparator result for that branch
//   jmp_i        J, JAL or JR in IF/ID
//   jr_i         JR in IF/ID (target comes from jr_addr_i)
//   jr_addr_i    rs value, JR target
//   bus          fetch_stage_if.master: imem port and IF/ID register
//   redirect_o   combinational: control-flow redirect taken this cycle
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                branch_i,
    input  logic                br_taken_i,
    input  logic                jmp_i,
    input  logic                jr_i,
    input  logic [PC_WIDTH-1:0] jr_addr_i,
    fetch_stage_if.master       bus,
    output logic                redirect_o
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    // Branch target: PC+4 plus the sign-extended word offset, wrapping
    // modulo 2^PC_WIDTH.
    function automatic logic [PC_WIDTH-1:0] branch_target(
        input logic [PC_WIDTH-1:0] pc4,
        input logic [15:0]         imm
    );
        logic signed [PC_WIDTH-1:0] offset;
        offset = {{(PC_WIDTH-18){imm[15]}}, imm, 2'b00};
        return pc4 + $unsigned(offset);
    endfunction

    // Pseudo-direct jump target: region bits from PC+4, index from the word.
    function automatic logic [PC_WIDTH-1:0] jump_target(
        input logic [PC_WIDTH-1:0] pc4,
        input logic [25:0]         index
    );
        return {pc4[PC_WIDTH-1:28], index, 2'b00};
    endfunction

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [31:0]         instr_p1, instr_d;
    logic [PC_WIDTH-1:0] pc4_p1, pc4_d;
    logic                vld_p1, vld_d;
    logic [PC_WIDTH-1:0] target;
    logic                redirect;

    // Stage 0: PC selection / memory address.
    // While stalled the memory re-reads the word it is already returning, so
    // the data lined up with fetch_pc_q survives the stall.
    assign bus.imem_addr = stall_i ? fetch_pc_q : pc_q;

    // A redirect only fires from a real instruction in IF/ID; during a stall
    // it is deferred because IF/ID keeps the branch until release.
    assign redirect   = vld_p1 & ~stall_i & (jmp_i | (branch_i & br_taken_i));
    assign redirect_o = redirect;

    always_comb begin
        if (jr_i) begin
            target = jr_addr_i;
        end else if (jmp_i) begin
            target = jump_target(pc4_p1, instr_p1[25:0]);
        end else begin
            target = branch_target(pc4_p1, instr_p1[15:0]);
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_p1;
        pc4_d      = pc4_p1;
        vld_d      = vld_p1;

        if (!stall_i) begin
            // Every unstalled cycle the address just issued becomes the one
            // whose data arrives next cycle.
            fetch_pc_d = pc_q;
            unique case (state_q)
                BOOT: begin
                    // No read has been issued yet: memory data is garbage.
                    instr_d = 32'h0;
                    vld_d   = 1'b0;
                    pc_d    = pc_q + PC_STEP;
                    state_d = RUN;
                end
                RUN: begin
                    if (redirect) begin
                        // Data arriving now is the first wrong-path word.
                        instr_d = 32'h0;
                        vld_d   = 1'b0;
                        pc_d    = target;
                        state_d = SQUASH;
                    end else begin
                        instr_d = bus.imem_rdata;
                        pc4_d   = fetch_pc_q + PC_STEP;
                        vld_d   = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                    end
                end
                SQUASH: begin
                    // Second wrong-path word; target data arrives next cycle.
                    instr_d = 32'h0;
                    vld_d   = 1'b0;
                    pc_d    = pc_q + PC_STEP;
                    state_d = RUN;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Stage 1: IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1 <= 32'h0;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            instr_p1 <= instr_d;
            pc4_p1   <= pc4_d;
            vld_p1   <= vld_d;
        end
    end

    assign bus.ifid_instr = instr_p1;
    assign bus.ifid_pc4   = pc4_p1;
    assign bus.ifid_valid = vld_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed control-flow scenarios followed by a randomized phase. The expected
// IF/ID contents and memory address come from an instruction-stream model:
// the next address to deliver, a count of bubbles still owed, and the address
// presented to memory last cycle.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          PW     = 32;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, branch_i, br_taken_i, jmp_i, jr_i;
    logic [31:0] jr_addr_i;
    logic        redirect_o;

    fetch_stage_if #(.PC_WIDTH(PW)) bus ();

    fetch_stage #(.PC_WIDTH(PW), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_i    (stall_i),
        .branch_i   (branch_i),
        .br_taken_i (br_taken_i),
        .jmp_i      (jmp_i),
        .jr_i       (jr_i),
        .jr_addr_i  (jr_addr_i),
        .bus        (bus),
        .redirect_o (redirect_o)
    );

    always #5 clk = ~clk;

    // Instruction memory: directed words override a default stream of ADDs.
    logic [31:0] prog [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        return {6'd0, a[6:2], a[11:7], a[16:12], 5'd0, 6'h20};
    endfunction

    always @(posedge clk) bus.imem_rdata <= mem_word(bus.imem_addr);

    // Reference model state
    logic [31:0] m_instr, m_pc4, next_pc, last_addr;
    logic        m_valid;
    int          bubbles;

    // Stimulus controls
    bit          rand_mode, take, jr_with_br, stall_req;
    logic [31:0] jr_target;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
        m_valid   = 1'b0;
        bubbles   = 1;
        next_pc   = RST_PC;
        last_addr = RST_PC;
    endtask

    task automatic drive_inputs();
        logic [5:0] op, fn;
        logic       is_jr;
        if (rand_mode) begin
            stall_i    = ($urandom_range(0, 4) == 0);
            branch_i   = ($urandom_range(0, 6) == 0);
            br_taken_i = 1'($urandom_range(0, 1));
            jmp_i      = ($urandom_range(0, 11) == 0);
            jr_i       = 1'($urandom_range(0, 1));
            jr_addr_i  = $urandom;
        end else begin
            // Act as the controller, decoding the word the model says is in IF/ID.
            op         = m_instr[31:26];
            fn         = m_instr[5:0];
            is_jr      = m_valid && op == 6'd0 && fn == 6'h08;
            branch_i   = (m_valid && (op == 6'h04 || op == 6'h05)) || (is_jr && jr_with_br);
            br_taken_i = take;
            jmp_i      = (m_valid && (op == 6'h02 || op == 6'h03)) || is_jr;
            jr_i       = is_jr;
            jr_addr_i  = jr_target;
            stall_i    = stall_req;
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model on
    // the edge, then check the IF/ID register.
    task automatic cycle();
        logic [31:0] exp_addr, tgt;
        logic        exp_redir;
        drive_inputs();
        @(negedge clk);
        exp_redir = m_valid && !stall_i && (jmp_i || (branch_i && br_taken_i));
        exp_addr  = stall_i ? last_addr : (bubbles != 0 ? next_pc : next_pc + 32'd4);
        chk("imem_addr", bus.imem_addr, exp_addr);
        chk("redirect", 32'(redirect_o), 32'(exp_redir));
        if (jr_i)       tgt = jr_addr_i;
        else if (jmp_i) tgt = {m_pc4[31:28], m_instr[25:0], 2'b00};
        else            tgt = m_pc4 + 32'($signed(m_instr[15:0]) * 4);
        if (!stall_i) begin
            if (exp_redir) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                bubbles = 1;
                next_pc = tgt;
            end else if (bubbles > 0) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                bubbles--;
            end else begin
                m_instr = mem_word(next_pc);
                m_pc4   = next_pc + 32'd4;
                m_valid = 1'b1;
                next_pc = next_pc + 32'd4;
            end
        end
        last_addr = exp_addr;
        @(posedge clk);
        #1;
        chk("ifid_instr", bus.ifid_instr, m_instr);
        chk("ifid_pc4", bus.ifid_pc4, m_pc4);
        chk("ifid_valid", 32'(bus.ifid_valid), 32'(m_valid));
    endtask

    // Advance until IF/ID holds the instruction whose PC+4 is pc4 (bounded).
    task automatic run_until(input string tag, input logic [31:0] pc4);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_valid && m_pc4 == pc4) found = 1'b1;
            else cycle();
        end
        chk(tag, bus.ifid_pc4, pc4);
    endtask

    // Assert reset a little after an edge and check it takes effect at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_instr", bus.ifid_instr, 32'h0);
        chk("rst_pc4", bus.ifid_pc4, 32'h0);
        chk("rst_valid", 32'(bus.ifid_valid), 32'h0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_redirect", 32'(redirect_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        stall_i    = 1'b0;
        branch_i   = 1'b0;
        br_taken_i = 1'b0;
        jmp_i      = 1'b0;
        jr_i       = 1'b0;
        jr_addr_i  = 32'h0;
        rand_mode  = 1'b0;
        take       = 1'b1;
        jr_with_br = 1'b1;
        stall_req  = 1'b0;
        jr_target  = 32'h200;

        prog[32'h10]  = {6'h04, 5'd1, 5'd2, 16'd3};       // BEQ +3 -> 0x20
        prog[32'h40]  = {6'h02, 26'h40};                  // J -> 0x100
        prog[32'h104] = {6'h04, 5'd3, 5'd4, 16'd5};       // BEQ, not taken
        prog[32'h10C] = {6'h00, 5'd31, 15'd0, 6'h08};     // JR $31
        prog[32'h208] = {6'h04, 5'd5, 5'd6, 16'd4};       // BEQ +4 -> 0x21C
        prog[32'h220] = {6'h05, 5'd7, 5'd8, 16'd8};       // BNE +8

        // Reset state
        #3;
        model_reset();
        chk("reset_instr", bus.ifid_instr, 32'h0);
        chk("reset_pc4", bus.ifid_pc4, 32'h0);
        chk("reset_valid", 32'(bus.ifid_valid), 32'h0);
        chk("reset_addr", bus.imem_addr, RST_PC);
        chk("reset_redirect", 32'(redirect_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sequential fetch from reset: BOOT bubble, then one per cycle
        cycle();
        chk("boot_bubble", 32'(bus.ifid_valid), 32'h0);
        cycle();
        chk("first_valid", 32'(bus.ifid_valid), 32'h1);
        chk("first_pc4", bus.ifid_pc4, 32'h4);
        repeat (2) cycle();

        // Taken BEQ at 0x10
        run_until("reach_beq", 32'h14);
        cycle();
        chk("beq_bubble1", 32'(bus.ifid_valid), 32'h0);
        cycle();
        chk("beq_bubble2", 32'(bus.ifid_valid), 32'h0);
        cycle();
        chk("beq_target_pc4", bus.ifid_pc4, 32'h24);

        // J at 0x40, then an untaken branch at 0x104
        run_until("reach_j", 32'h44);
        repeat (2) cycle();
        cycle();
        chk("j_target_pc4", bus.ifid_pc4, 32'h104);
        take = 1'b0;
        run_until("reach_bnt", 32'h108);
        cycle();
        chk("bnt_seq_pc4", bus.ifid_pc4, 32'h10C);
        chk("bnt_seq_valid", 32'(bus.ifid_valid), 32'h1);
        take = 1'b1;

        // JR with branch asserted too: JR target wins
        run_until("reach_jr", 32'h110);
        cycle();
        chk("jr_pc", bus.imem_addr, 32'h200);
        repeat (2) cycle();
        chk("jr_target_pc4", bus.ifid_pc4, 32'h204);

        // Three-cycle stall arriving with a pending BEQ in IF/ID
        run_until("reach_stall_beq", 32'h20C);
        stall_req = 1'b1;
        repeat (3) cycle();
        chk("stall_frozen_pc4", bus.ifid_pc4, 32'h20C);
        stall_req = 1'b0;
        cycle();
        chk("stall_redirect_bubble", 32'(bus.ifid_valid), 32'h0);
        repeat (2) cycle();
        chk("stall_target_pc4", bus.ifid_pc4, 32'h220);

        // Reset during SQUASH
        run_until("reach_bne", 32'h224);
        cycle();
        do_reset();
        cycle();
        chk("rerun_boot_bubble", 32'(bus.ifid_valid), 32'h0);
        cycle();
        chk("rerun_first_pc4", bus.ifid_pc4, 32'h4);

        // Randomized phase with occasional resets
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
